// File: rtl/cache_pkg.sv
// Shared cache geometry, block types and the miss-handler state encoding.
package cache_pkg;

    localparam int unsigned NumSets       = 4;
    localparam int unsigned Associativity = 2;
    localparam int unsigned SetWidth      = $clog2(NumSets);
    localparam int unsigned TagWidth      = 4;
    localparam int unsigned DataWidth     = 8;
    localparam int unsigned WayWidth      = (Associativity > 1) ? $clog2(Associativity) : 1;

    typedef struct packed {
        logic                valid;
        logic [TagWidth-1:0] tag;
    } block_info_t;

    typedef logic [DataWidth-1:0] block_data_t;

    // Info for every way of one set, way 0 in the least significant slot.
    typedef block_info_t [Associativity-1:0] set_info_t;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLookup,
        StMemReq,
        StMemWait,
        StFill,
        StResp
    } miss_state_e;

endpackage

// File: rtl/cache_miss_handler_if.sv
// Request/response handshake bus between a client and the miss handler.
interface cache_miss_handler_if
    import cache_pkg::*;
;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [SetWidth-1:0] req_set_i;
    logic [TagWidth-1:0] req_tag_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    block_data_t         resp_data_o;
    logic                resp_error_o;

    // Handler side.
    modport slave (
        input  req_valid_i, req_set_i, req_tag_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_error_o
    );

    // Client side.
    modport master (
        output req_valid_i, req_set_i, req_tag_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_error_o
    );

endinterface

// File: rtl/cache_victim_select.sv
// Picks the way to refill: lowest invalid way, otherwise the round-robin way.
module cache_victim_select
    import cache_pkg::*;
(
    input  set_info_t           i_set_info,
    input  logic [WayWidth-1:0] i_rr_ptr,
    output logic [WayWidth-1:0] o_victim_way,
    output logic                o_replace
);

    // Scan from the top way down so the lowest invalid way wins.
    always_comb begin
        o_replace    = 1'b1;
        o_victim_way = i_rr_ptr;
        for (int w = Associativity - 1; w >= 0; w--) begin
            if (!i_set_info[w].valid) begin
                o_replace    = 1'b0;
                o_victim_way = WayWidth'(w);
            end
        end
    end

endmodule

// File: rtl/cache_miss_handler.sv
// Blocking miss handler: one outstanding request, single-beat refill,
// optional memory timeout, shadow copy of the cache tag/valid state.
module cache_miss_handler
    import cache_pkg::*;
#(
    parameter int unsigned MemTimeoutCycles = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    cache_miss_handler_if.slave          bus,
    output logic [SetWidth-1:0]          lookup_set_o,
    output logic [TagWidth-1:0]          lookup_tag_o,
    input  logic                         lookup_hit_i,
    input  block_data_t                  lookup_data_i,
    output logic                         mem_req_valid_o,
    input  logic                         mem_req_ready_i,
    output logic [TagWidth+SetWidth-1:0] mem_req_addr_o,
    input  logic                         mem_resp_valid_i,
    input  block_data_t                  mem_resp_data_i,
    output logic                         cache_write_en_o,
    output logic [SetWidth-1:0]          cache_write_set_o,
    output set_info_t                    cache_write_info_o,
    output logic [WayWidth-1:0]          cache_write_data_way_o,
    output block_data_t                  cache_write_data_o
);

    // One extra bit keeps the counter from wrapping before the compare hits.
    localparam int unsigned TimerWidth = $clog2(MemTimeoutCycles + 1) + 1;

    miss_state_e                         r_state;
    logic [SetWidth-1:0]                 r_sweep;
    logic [SetWidth-1:0]                 r_req_set;
    logic [TagWidth-1:0]                 r_req_tag;
    logic [TimerWidth-1:0]               r_timer;
    set_info_t [NumSets-1:0]             r_shadow;
    logic [NumSets-1:0][WayWidth-1:0]    r_rr;
    logic                                r_req_ready;
    logic                                r_resp_valid;
    block_data_t                         r_resp_data;
    logic                                r_resp_error;
    logic                                r_mem_req_valid;
    logic                                r_wr_en;
    logic [SetWidth-1:0]                 r_wr_set;
    set_info_t                           r_wr_info;
    logic [WayWidth-1:0]                 r_wr_way;
    block_data_t                         r_wr_data;

    logic [WayWidth-1:0]                 w_victim_way;
    logic                                w_replace;
    logic [WayWidth-1:0]                 w_rr_cur;
    logic [WayWidth-1:0]                 w_rr_next;
    set_info_t                           w_fill_info;

    cache_victim_select u_victim (
        .i_set_info   (r_shadow[r_req_set]),
        .i_rr_ptr     (w_rr_cur),
        .o_victim_way (w_victim_way),
        .o_replace    (w_replace)
    );

    // Set info after installing the request tag in the victim way.
    always_comb begin
        w_rr_cur                        = r_rr[r_req_set];
        w_rr_next                       = (w_rr_cur == WayWidth'(Associativity - 1)) ?
                                          '0 : w_rr_cur + 1'b1;
        w_fill_info                     = r_shadow[r_req_set];
        w_fill_info[w_victim_way].valid = 1'b1;
        w_fill_info[w_victim_way].tag   = r_req_tag;
    end

    // Main FSM; every output is registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= StInit;
            r_sweep         <= '0;
            r_req_set       <= '0;
            r_req_tag       <= '0;
            r_timer         <= '0;
            r_shadow        <= '0;
            r_rr            <= '0;
            r_req_ready     <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_data     <= '0;
            r_resp_error    <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_set        <= '0;
            r_wr_info       <= '0;
            r_wr_way        <= '0;
            r_wr_data       <= '0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                StInit: begin
                    r_wr_en           <= 1'b1;
                    r_wr_set          <= r_sweep;
                    r_wr_info         <= '0;
                    r_wr_way          <= '0;
                    r_wr_data         <= '0;
                    r_shadow[r_sweep] <= '0;
                    if (r_sweep == SetWidth'(NumSets - 1)) begin
                        r_sweep     <= '0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end
                StIdle: begin
                    if (bus.req_valid_i) begin
                        r_req_set   <= bus.req_set_i;
                        r_req_tag   <= bus.req_tag_i;
                        r_req_ready <= 1'b0;
                        r_state     <= StLookup;
                    end
                end
                StLookup: begin
                    if (lookup_hit_i) begin
                        r_resp_data  <= lookup_data_i;
                        r_resp_error <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= StResp;
                    end else begin
                        r_mem_req_valid <= 1'b1;
                        r_state         <= StMemReq;
                    end
                end
                StMemReq: begin
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_timer         <= '0;
                        r_state         <= StMemWait;
                    end
                end
                StMemWait: begin
                    // A response on the timeout cycle still wins over the error.
                    if (mem_resp_valid_i) begin
                        r_wr_en             <= 1'b1;
                        r_wr_set            <= r_req_set;
                        r_wr_info           <= w_fill_info;
                        r_wr_way            <= w_victim_way;
                        r_wr_data           <= mem_resp_data_i;
                        r_shadow[r_req_set] <= w_fill_info;
                        if (w_replace) begin
                            r_rr[r_req_set] <= w_rr_next;
                        end
                        r_state <= StFill;
                    end else if ((MemTimeoutCycles != 0) &&
                                 (r_timer == TimerWidth'(MemTimeoutCycles - 1))) begin
                        r_resp_valid <= 1'b1;
                        r_resp_error <= 1'b1;
                        r_resp_data  <= '0;
                        r_state      <= StResp;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StFill: begin
                    r_resp_valid <= 1'b1;
                    r_resp_error <= 1'b0;
                    r_resp_data  <= r_wr_data;
                    r_state      <= StResp;
                end
                StResp: begin
                    if (bus.resp_ready_i) begin
                        r_resp_valid <= 1'b0;
                        r_resp_error <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign bus.req_ready_o            = r_req_ready;
    assign bus.resp_valid_o           = r_resp_valid;
    assign bus.resp_data_o            = r_resp_data;
    assign bus.resp_error_o           = r_resp_error;
    assign lookup_set_o               = r_req_set;
    assign lookup_tag_o               = r_req_tag;
    assign mem_req_valid_o            = r_mem_req_valid;
    assign mem_req_addr_o             = {r_req_tag, r_req_set};
    assign cache_write_en_o           = r_wr_en;
    assign cache_write_set_o          = r_wr_set;
    assign cache_write_info_o         = r_wr_info;
    assign cache_write_data_way_o     = r_wr_way;
    assign cache_write_data_o         = r_wr_data;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Scoreboard bench for cache_miss_handler (2 ways, 4 sets, timeout 8).
module tb_cache_miss_handler;
    import cache_pkg::*;

    localparam int unsigned InfoBits = Associativity * (1 + TagWidth);

    logic                         clk_i = 1'b0;
    logic                         rst_i = 1'b1;
    logic [SetWidth-1:0]          lookup_set_o;
    logic [TagWidth-1:0]          lookup_tag_o;
    logic                         lookup_hit_i;
    block_data_t                  lookup_data_i;
    logic                         mem_req_valid_o;
    logic                         mem_req_ready_i = 1'b0;
    logic [TagWidth+SetWidth-1:0] mem_req_addr_o;
    logic                         mem_resp_valid_i = 1'b0;
    block_data_t                  mem_resp_data_i = '0;
    logic                         cache_write_en_o;
    logic [SetWidth-1:0]          cache_write_set_o;
    set_info_t                    cache_write_info_o;
    logic [WayWidth-1:0]          cache_write_data_way_o;
    block_data_t                  cache_write_data_o;

    cache_miss_handler_if u_if ();

    cache_miss_handler #(.MemTimeoutCycles(8)) u_dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .bus                    (u_if),
        .lookup_set_o           (lookup_set_o),
        .lookup_tag_o           (lookup_tag_o),
        .lookup_hit_i           (lookup_hit_i),
        .lookup_data_i          (lookup_data_i),
        .mem_req_valid_o        (mem_req_valid_o),
        .mem_req_ready_i        (mem_req_ready_i),
        .mem_req_addr_o         (mem_req_addr_o),
        .mem_resp_valid_i       (mem_resp_valid_i),
        .mem_resp_data_i        (mem_resp_data_i),
        .cache_write_en_o       (cache_write_en_o),
        .cache_write_set_o      (cache_write_set_o),
        .cache_write_info_o     (cache_write_info_o),
        .cache_write_data_way_o (cache_write_data_way_o),
        .cache_write_data_o     (cache_write_data_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [SetWidth-1:0] set;
        logic [WayWidth-1:0] way;
        logic [InfoBits-1:0] info;
        logic [DataWidth-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic [DataWidth-1:0] data;
        logic                 err;
    } resp_exp_t;

    wr_exp_t   wr_q[$];
    resp_exp_t resp_q[$];
    int        n_writes = 0;
    int        n_resp = 0;
    int        exp_resp = 0;
    int        n_memreq = 0;
    int        acc_cyc = 0;
    int        mem_acc_cyc = 0;
    int        resp_first_cyc = 0;
    logic      resp_prev = 1'b0;
    logic      memreq_prev = 1'b0;

    // Behavioural cache array, updated only from the DUT's write port.
    logic                 mdl_valid [NumSets][Associativity];
    logic [TagWidth-1:0]  mdl_tag   [NumSets][Associativity];
    logic [DataWidth-1:0] mdl_data  [NumSets][Associativity];

    always_comb begin
        lookup_hit_i  = 1'b0;
        lookup_data_i = '0;
        for (int w = 0; w < Associativity; w++) begin
            if (mdl_valid[lookup_set_o][w] === 1'b1 && mdl_tag[lookup_set_o][w] == lookup_tag_o) begin
                lookup_hit_i  = 1'b1;
                lookup_data_i = mdl_data[lookup_set_o][w];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [InfoBits-1:0] mk_info(input logic v1, input logic [3:0] t1,
                                                    input logic v0, input logic [3:0] t0);
        return {v1, t1, v0, t0};
    endfunction

    // Monitor: sample mid-cycle, compare writes and responses against the queues.
    always @(negedge clk_i) begin
        if (!rst_i && cache_write_en_o) begin
            n_writes++;
            for (int w = 0; w < Associativity; w++) begin
                mdl_valid[cache_write_set_o][w] = cache_write_info_o[w].valid;
                mdl_tag[cache_write_set_o][w]   = cache_write_info_o[w].tag;
            end
            mdl_data[cache_write_set_o][cache_write_data_way_o] = cache_write_data_o;
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("wr_set", 32'(cache_write_set_o), 32'(e.set));
                check("wr_way", 32'(cache_write_data_way_o), 32'(e.way));
                check("wr_info", 32'(cache_write_info_o), 32'(e.info));
                check("wr_data", 32'(cache_write_data_o), 32'(e.data));
            end
        end
        if (u_if.resp_valid_o && !resp_prev) resp_first_cyc = cyc;
        resp_prev = u_if.resp_valid_o;
        if (mem_req_valid_o && !memreq_prev) n_memreq++;
        memreq_prev = mem_req_valid_o;
        if (u_if.resp_valid_o && u_if.resp_ready_i) begin
            n_resp++;
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                resp_exp_t r;
                r = resp_q.pop_front();
                check("resp_data", 32'(u_if.resp_data_o), 32'(r.data));
                check("resp_error", 32'(u_if.resp_error_o), 32'(r.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_write(input int set, input int way, input logic [InfoBits-1:0] info,
                                input logic [7:0] data);
        wr_exp_t e;
        e.set  = SetWidth'(set);
        e.way  = WayWidth'(way);
        e.info = info;
        e.data = data;
        wr_q.push_back(e);
    endtask

    task automatic expect_resp(input logic [7:0] data, input logic err);
        resp_exp_t r;
        r.data = data;
        r.err  = err;
        resp_q.push_back(r);
        exp_resp++;
    endtask

    task automatic send_req(input int set, input int tag);
        int guard = 0;
        u_if.req_valid_i = 1'b1;
        u_if.req_set_i   = SetWidth'(set);
        u_if.req_tag_i   = TagWidth'(tag);
        while (!u_if.req_ready_o && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("req_accept_bound", 32'd0, 32'd1);
        acc_cyc = cyc;
        tick();
        u_if.req_valid_i = 1'b0;
    endtask

    // Accept the refill request after 'stall' cycles; reply 'delay' cycles
    // into MEM_WAIT, or never when delay is negative.
    task automatic mem_serve(input logic [5:0] addr, input int stall, input int delay,
                             input logic [7:0] data);
        int guard = 0;
        while (!mem_req_valid_o && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            check("mem_req_bound", 32'd0, 32'd1);
            return;
        end
        check("mem_addr", 32'(mem_req_addr_o), 32'(addr));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("mem_req_held", 32'({mem_req_valid_o, mem_req_addr_o}), 32'({1'b1, addr}));
        end
        mem_req_ready_i = 1'b1;
        mem_acc_cyc     = cyc;
        tick();
        mem_req_ready_i = 1'b0;
        if (delay >= 0) begin
            repeat (delay) tick();
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = data;
            tick();
            mem_resp_valid_i = 1'b0;
            mem_resp_data_i  = '0;
        end
    endtask

    task automatic wait_resp();
        int guard = 0;
        while (n_resp < exp_resp && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("resp_bound", 32'(n_resp), 32'(exp_resp));
        tick();
    endtask

    task automatic reset_and_init();
        int w0;
        int guard = 0;
        rst_i = 1'b1;
        #1;
        check("rst_req_ready", 32'(u_if.req_ready_o), 32'd0);
        check("rst_resp_valid", 32'(u_if.resp_valid_o), 32'd0);
        check("rst_resp_data", 32'(u_if.resp_data_o), 32'd0);
        check("rst_mem_req", 32'({mem_req_valid_o, mem_req_addr_o}), 32'd0);
        check("rst_wr_en", 32'(cache_write_en_o), 32'd0);
        check("rst_lookup", 32'({lookup_set_o, lookup_tag_o}), 32'd0);
        tick();
        tick();
        for (int s = 0; s < NumSets; s++) expect_write(s, 0, '0, 8'h00);
        w0    = n_writes;
        rst_i = 1'b0;
        while (!u_if.req_ready_o && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        check("init_strobes", 32'(n_writes - w0), 32'd4);
        check("init_ready", 32'(u_if.req_ready_o), 32'd1);
        check("init_queue_empty", 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int m0;
        int w0;
        logic [7:0] held_data;
        u_if.req_valid_i  = 1'b0;
        u_if.req_set_i    = '0;
        u_if.req_tag_i    = '0;
        u_if.resp_ready_i = 1'b1;
        tick();
        reset_and_init();

        // Miss in set 1, memory stalls the request 2 cycles.
        expect_write(1, 0, mk_info(1'b0, 4'h0, 1'b1, 4'h5), 8'hAB);
        expect_resp(8'hAB, 1'b0);
        send_req(1, 5);
        mem_serve(6'h15, 2, 2, 8'hAB);
        wait_resp();

        // Hit on the same line: two-cycle latency, no refill.
        m0 = n_memreq;
        expect_resp(8'hAB, 1'b0);
        send_req(1, 5);
        wait_resp();
        check("hit_latency", 32'(resp_first_cyc - acc_cyc), 32'd2);
        check("hit_no_mem_req", 32'(n_memreq - m0), 32'd0);

        // Set 2 replacement order: way 0, way 1, then round-robin 0, 1.
        expect_write(2, 0, mk_info(1'b0, 4'h0, 1'b1, 4'h6), 8'h16);
        expect_resp(8'h16, 1'b0);
        send_req(2, 6);
        mem_serve(6'h1A, 0, 0, 8'h16);
        wait_resp();
        expect_write(2, 1, mk_info(1'b1, 4'h7, 1'b1, 4'h6), 8'h17);
        expect_resp(8'h17, 1'b0);
        send_req(2, 7);
        mem_serve(6'h1E, 0, 1, 8'h17);
        wait_resp();
        expect_write(2, 0, mk_info(1'b1, 4'h7, 1'b1, 4'h8), 8'h18);
        expect_resp(8'h18, 1'b0);
        send_req(2, 8);
        mem_serve(6'h22, 0, 0, 8'h18);
        wait_resp();
        expect_write(2, 1, mk_info(1'b1, 4'h9, 1'b1, 4'h8), 8'h19);
        expect_resp(8'h19, 1'b0);
        send_req(2, 9);
        mem_serve(6'h26, 0, 0, 8'h19);
        wait_resp();

        // Timeout: error after 8 MEM_WAIT cycles, no write.
        expect_resp(8'h00, 1'b1);
        send_req(3, 'hA);
        mem_serve(6'h2B, 0, -1, 8'h00);
        wait_resp();
        check("timeout_cycles", 32'(resp_first_cyc - mem_acc_cyc), 32'd9);
        // Late memory response while idle must be ignored.
        w0 = n_writes;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 8'h77;
        tick();
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        repeat (3) tick();
        check("late_resp_no_write", 32'(n_writes - w0), 32'd0);
        check("late_resp_no_resp", 32'(n_resp), 32'(exp_resp));
        check("late_resp_idle", 32'(u_if.req_ready_o), 32'd1);

        // Response on the final timeout cycle counts as data.
        expect_write(0, 0, mk_info(1'b0, 4'h0, 1'b1, 4'hB), 8'hCD);
        expect_resp(8'hCD, 1'b0);
        send_req(0, 'hB);
        mem_serve(6'h2C, 0, 7, 8'hCD);
        wait_resp();

        // Backpressure: response held for 5 cycles.
        u_if.resp_ready_i = 1'b0;
        expect_write(3, 0, mk_info(1'b0, 4'h0, 1'b1, 4'hC), 8'h3C);
        expect_resp(8'h3C, 1'b0);
        send_req(3, 'hC);
        mem_serve(6'h33, 0, 0, 8'h3C);
        begin
            int guard = 0;
            while (!u_if.resp_valid_o && guard < 50) begin
                tick();
                guard++;
            end
        end
        held_data = u_if.resp_data_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_held", 32'({u_if.resp_valid_o, u_if.resp_error_o, u_if.resp_data_o}),
                  32'({1'b1, 1'b0, held_data}));
            check("bp_not_ready", 32'(u_if.req_ready_o), 32'd0);
        end
        u_if.resp_ready_i = 1'b1;
        wait_resp();

        // Reset while waiting on memory: abort and re-sweep.
        send_req(1, 'hD);
        mem_serve(6'h35, 0, -1, 8'h00);
        repeat (3) tick();
        reset_and_init();

        // Shadow state cleared: set 1 refills into way 0 again.
        expect_write(1, 0, mk_info(1'b0, 4'h0, 1'b1, 4'h5), 8'h11);
        expect_resp(8'h11, 1'b0);
        send_req(1, 5);
        mem_serve(6'h15, 0, 0, 8'h11);
        wait_resp();

        check("final_wr_q", 32'(wr_q.size()), 32'd0);
        check("final_resp_q", 32'(resp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
